fsm_debounce_multi: RTL
=======================

FSM_DEBOUNCE_MULTI -- requirements
Module: fsm_debounce_multi

Interface
REQ-001 SHALL provide parameter CH, default 4, number of independent input channels (1..32).
REQ-002 SHALL provide parameter STABLE, default 3, number of consecutive differing samples required to change an output (1..255).
REQ-003 SHALL provide port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL provide port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port x  input  CH  raw per-channel level inputs.
REQ-006 SHALL provide port y  output  CH  registered, filtered level per channel.
REQ-007 SHALL provide port rise  output  CH  one-cycle pulse per channel, coincident with the y 0->1 change.
REQ-008 SHALL provide port fall  output  CH  one-cycle pulse per channel, coincident with the y 1->0 change.

Function
REQ-009 Each channel SHALL run an independent 4-state FSM: ST_LO, CONF_HI, ST_HI, CONF_LO.
REQ-010 Each channel SHALL hold a counter of width $clog2(STABLE+1) that counts consecutive samples with x != y.
REQ-011 ST_LO with x=1: if STABLE=1, go to ST_HI; otherwise go to CONF_HI with count=1.
REQ-012 CONF_HI with x=1: increment count; on the sample where the count reaches STABLE, go to ST_HI and clear the count.
REQ-013 CONF_HI with x=0: return to ST_LO and clear the count; y, rise and fall SHALL stay unchanged (glitch rejected).
REQ-014 ST_HI, CONF_LO and ST_LO SHALL behave as the mirror image of REQ-011..013 with 0 and 1 swapped.
REQ-015 y SHALL be 1 exactly when the channel is in ST_HI or CONF_LO, driven from a register.
REQ-016 Latency: a level held from edge t SHALL appear on y after edge t+STABLE-1; with STABLE=1, y equals x delayed by one clock.
REQ-017 rise/fall SHALL be registered, asserted for exactly one cycle, and never asserted together on one channel.
REQ-018 The counter SHALL never exceed STABLE; no wrap-around is permitted.
REQ-019 Simultaneous changes on several channels SHALL be processed independently in the same cycle, with no priority between channels.

Reset
REQ-020 While reset is high, all channels SHALL be in ST_LO, with counters=0, y=0, rise=0 and fall=0.
REQ-021 Reset asserted mid-confirmation SHALL discard the partial count; after release, a full STABLE samples are required.
REQ-022 Reset SHALL take effect immediately, independent of clk; release SHALL be sampled on the next rising clk edge.

Configuration
REQ-023 Macro FSM_DEBOUNCE_SYNC_EN defined: x SHALL pass through a 2-flop synchroniser per channel (reset to 0) before the FSM, adding exactly 2 cycles of latency.
REQ-024 Macro FSM_DEBOUNCE_SYNC_EN undefined: x SHALL feed the FSM directly, with no added latency or flops.

Structure
REQ-025 State encodings (2-bit ST_LO=0, CONF_HI=1, ST_HI=2, CONF_LO=3) SHALL live in shared package fsm_pkg.
REQ-026 Per-channel logic SHALL be sub-module fsm_debounce_chan (parameter STABLE), instantiated CH times by a generate loop.
REQ-027 The top level SHALL contain only the generate loop and the optional synchroniser.

Verification (CH=4, STABLE=3, macro undefined unless stated)
REQ-028 Reset held with x=4'hF -> y=0, rise=0 and fall=0 throughout reset.
REQ-029 x[0] 0->1 held -> y[0]=1 and rise[0]=1 for one cycle, both appearing after the 3rd sampling edge; other channels stay 0.
REQ-030 x[1] high for 2 cycles then low -> y[1] stays 0, with no rise or fall pulse.
REQ-031 x=4'hF held until y=4'hF, then x=4'h0 -> fall=4'hF pulsed in a single cycle, then y=4'h0.
REQ-032 Reset pulsed after 2 high samples on x[2] -> y[2]=0; after release, 3 further high samples are needed before rise[2].
REQ-033 STABLE=1 with random x -> y matches x delayed 1 cycle; with FSM_DEBOUNCE_SYNC_EN defined -> delayed 3 cycles.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared state encoding for the per-channel debounce FSM.
package fsm_pkg;

   typedef enum logic [1:0] {
      ST_LO   = 2'd0,
      CONF_HI = 2'd1,
      ST_HI   = 2'd2,
      CONF_LO = 2'd3
   } state_t;

endpackage

// File: rtl/fsm_debounce_chan.sv
// Single-channel debouncer: y changes only after STABLE consecutive samples
// differing from the current level; rise/fall pulse on that change.
module fsm_debounce_chan
   import fsm_pkg::*;
#(
   parameter int unsigned STABLE = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic x,
   output logic y,
   output logic rise,
   output logic fall
);

   localparam int unsigned W = $clog2(STABLE + 1);
   localparam logic [W-1:0] LAST = W'(STABLE);
   localparam logic [W-1:0] ONE  = W'(1);

   state_t         state;
   logic [W-1:0]   cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_LO;
         cnt   <= '0;
         y     <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         unique case (state)
            ST_LO: begin
               if (x) begin
                  if (STABLE == 1) begin
                     state <= ST_HI;
                     y     <= 1'b1;
                     rise  <= 1'b1;
                  end else begin
                     state <= CONF_HI;
                     cnt   <= ONE;
                  end
               end
            end
            CONF_HI: begin
               if (!x) begin
                  // Glitch rejected: drop the partial count, outputs untouched.
                  state <= ST_LO;
                  cnt   <= '0;
               end else if (cnt + ONE == LAST) begin
                  state <= ST_HI;
                  cnt   <= '0;
                  y     <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            ST_HI: begin
               if (!x) begin
                  if (STABLE == 1) begin
                     state <= ST_LO;
                     y     <= 1'b0;
                     fall  <= 1'b1;
                  end else begin
                     state <= CONF_LO;
                     cnt   <= ONE;
                  end
               end
            end
            CONF_LO: begin
               if (x) begin
                  state <= ST_HI;
                  cnt   <= '0;
               end else if (cnt + ONE == LAST) begin
                  state <= ST_LO;
                  cnt   <= '0;
                  y     <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/fsm_debounce_multi.sv
// CH independent debounce channels; define FSM_DEBOUNCE_SYNC_EN to insert a
// 2-flop input synchroniser (2 cycles extra latency) ahead of each channel.
module fsm_debounce_multi #(
   parameter int unsigned CH     = 4,
   parameter int unsigned STABLE = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CH-1:0] x,
   output logic [CH-1:0] y,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall
);

   logic [CH-1:0] xs;

`ifdef FSM_DEBOUNCE_SYNC_EN
   logic [CH-1:0] sync1, sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= x;
         sync2 <= sync1;
      end
   end

   assign xs = sync2;
`else
   assign xs = x;
`endif

   for (genvar i = 0; i < CH; i++) begin : g_chan
      fsm_debounce_chan #(
         .STABLE(STABLE)
      ) u_chan (
         .clk  (clk),
         .reset(reset),
         .x    (xs[i]),
         .y    (y[i]),
         .rise (rise[i]),
         .fall (fall[i])
      );
   end

endmodule
